// File: rtl/hazard_pkg.sv
// Shared definitions for the register-hazard scoreboard: latency classes,
// default register-file geometry and a latency clamp helper.
package hazard_pkg;

    localparam int unsigned LAT_ALU          = 1;
    localparam int unsigned LAT_LOAD         = 2;
    localparam int unsigned LAT_MULDIV       = 4;

    localparam int unsigned DEFAULT_NUM_REGS = 32;
    localparam int unsigned DEFAULT_REG_W    = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_REG_W-1:0] reg_num_t;

    // Latency 0 behaves like an ALU op; anything above max_lat is clamped.
    function automatic int unsigned eff_lat(input int unsigned lat,
                                            input int unsigned max_lat);
        if (lat == 0) begin
            return 1;
        end
        if (lat > max_lat) begin
            return max_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-result down-counter: load wins over decrement,
// hold freezes the count, busy flags a not-yet-forwardable result.
module sb_counter #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic             busy_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard beside ID: one down-counter per register,
// stall while any used source is pending, saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned MAX_LAT  = LAT_MULDIV,
    parameter int unsigned REG_W    = $clog2(NUM_REGS),
    parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_src_num,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic                     id_dst_we,
    input  logic [REG_W-1:0]         id_dst_num,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic                     flush,
    input  logic                     pipe_hold,
    output logic                     stall_id,
    output logic                     issue,
    output logic [31:0]              stall_cycles
);

    // Busy vector spans every encodable register number so that lookups
    // never index past the end; slots outside the register file read idle.
    localparam int unsigned NUM_SLOTS = 1 << REG_W;

    logic [NUM_SLOTS-1:0] busy;
    logic                 hz;
    logic                 dst_load;
    logic [LAT_W-1:0]     load_val;
    logic [31:0]          stall_cycles_q;
    logic [31:0]          stall_cycles_d;

    always_comb begin
        logic [REG_W-1:0] src;
        hz  = 1'b0;
        src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = id_src_num[i*REG_W +: REG_W];
            if (id_src_used[i] && (src != '0) && busy[src]) begin
                hz = 1'b1;
            end
        end
    end

    assign stall_id = id_valid && !flush && hz;
    assign issue    = id_valid && !flush && !hz && !pipe_hold;
    assign dst_load = issue && id_dst_we && (id_dst_num != '0);
    assign load_val = LAT_W'(eff_lat(32'(id_lat), MAX_LAT) - 1);

    for (genvar r = 0; r < NUM_SLOTS; r++) begin : g_reg
        if ((r >= 1) && (r < NUM_REGS)) begin : g_cnt
            sb_counter #(
                .LAT_W (LAT_W)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .hold_i     (pipe_hold),
                .load_i     (dst_load && (id_dst_num == REG_W'(r))),
                .load_val_i (load_val),
                .busy_o     (busy[r])
            );
        end else begin : g_zero
            assign busy[r] = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_id && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, compared against a remaining-cycles-per-register model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NR = 32;
    localparam int NS = 2;
    localparam int ML = 4;
    localparam int RW = 5;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [NS*RW-1:0] id_src_num;
    logic [NS-1:0]    id_src_used;
    logic             id_dst_we;
    logic [RW-1:0]    id_dst_num;
    logic [LW-1:0]    id_lat;
    logic             flush;
    logic             pipe_hold;
    logic             stall_id;
    logic             issue;
    logic [31:0]      stall_cycles;

    int          rem [NR];
    int unsigned sc_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    hazard_scoreboard #(
        .NUM_REGS (NR),
        .NUM_SRC  (NS),
        .MAX_LAT  (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src_num   (id_src_num),
        .id_src_used  (id_src_used),
        .id_dst_we    (id_dst_we),
        .id_dst_num   (id_dst_num),
        .id_lat       (id_lat),
        .flush        (flush),
        .pipe_hold    (pipe_hold),
        .stall_id     (stall_id),
        .issue        (issue),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input int s0, input int s1, input bit [1:0] used,
                          input bit we, input int dst, input int lat,
                          input bit fl, input bit hd);
        id_valid    = v;
        id_src_num  = {RW'(s1), RW'(s0)};
        id_src_used = used;
        id_dst_we   = we;
        id_dst_num  = RW'(dst);
        id_lat      = LW'(lat);
        flush       = fl;
        pipe_hold   = hd;
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) rem[r] = 0;
        sc_m = 0;
    endtask

    // Called one time unit after a rising edge with inputs already applied.
    task automatic step(input string tag);
        bit       hz;
        bit       es;
        bit       ei;
        reg_num_t s;
        int       d;
        int       l;
        hz = 0;
        for (int i = 0; i < NS; i++) begin
            s = id_src_num[i*RW +: RW];
            if (id_src_used[i] && s != 0 && rem[s] > 0) hz = 1;
        end
        es = id_valid && !flush && hz;
        ei = id_valid && !flush && !hz && !pipe_hold;
        #3;
        check({tag, ".stall"}, {31'b0, stall_id}, {31'b0, es});
        check({tag, ".issue"}, {31'b0, issue}, {31'b0, ei});
        check({tag, ".sc"}, stall_cycles, sc_m);
        @(posedge clk);
        if (es && sc_m != 32'hFFFF_FFFF) sc_m++;
        if (!pipe_hold) begin
            d = int'(id_dst_num);
            l = int'(id_lat);
            if (l == 0) l = 1;
            if (l > ML) l = ML;
            for (int r = 1; r < NR; r++) begin
                if (ei && id_dst_we && r == d) rem[r] = l - 1;
                else if (rem[r] > 0) rem[r]--;
            end
        end
        #1;
    endtask

    initial begin
        int unsigned sc0;
        model_clear();
        rst = 1'b1;
        set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #2;
        check("rst.stall", {31'b0, stall_id}, 32'd0);
        check("rst.sc", stall_cycles, 32'd0);
        set_in(1, 3, 4, 2'b11, 0, 0, 0, 0, 0);
        #5;
        check("rst.issue", {31'b0, issue}, 32'd1);
        pipe_hold = 1'b1;
        #1;
        check("rst.issue_hold", {31'b0, issue}, 32'd0);
        set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // load-use: lat=2 producer to r8, consumer right behind
        sc0 = sc_m;
        set_in(1, 0, 0, 2'b00, 1, 8, LAT_LOAD, 0, 0); step("lu.prod");
        set_in(1, 8, 0, 2'b01, 0, 0, 1, 0, 0);        step("lu.c1");
        set_in(1, 8, 0, 2'b01, 0, 0, 1, 0, 0);        step("lu.c2");
        check("lu.len", stall_cycles - sc0, 32'd1);

        // ALU chain on src1
        sc0 = sc_m;
        set_in(1, 0, 0, 2'b00, 1, 3, LAT_ALU, 0, 0); step("alu.prod");
        set_in(1, 0, 3, 2'b10, 1, 6, LAT_ALU, 0, 0); step("alu.cons");
        check("alu.len", stall_cycles - sc0, 32'd0);

        // lat=4 producer, hold for two cycles mid-stall
        sc0 = sc_m;
        set_in(1, 0, 0, 2'b00, 1, 5, LAT_MULDIV, 0, 0); step("hold.prod");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 0);          step("hold.c1");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 1);          step("hold.h1");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 1);          step("hold.h2");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 0);          step("hold.c2");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 0);          step("hold.c3");
        set_in(1, 5, 5, 2'b11, 0, 0, 1, 0, 0);          step("hold.c4");
        check("hold.len", stall_cycles - sc0, 32'd5);

        // r0 never pending; unused source ignored
        sc0 = sc_m;
        set_in(1, 0, 0, 2'b00, 1, 0, LAT_MULDIV, 0, 0); step("r0.prod");
        set_in(1, 0, 0, 2'b00, 1, 7, LAT_MULDIV, 0, 0); step("r7.prod");
        set_in(1, 0, 0, 2'b11, 0, 0, 1, 0, 0);          step("r0.cons");
        set_in(1, 7, 7, 2'b00, 0, 0, 1, 0, 0);          step("r7.unused");
        check("r0.len", stall_cycles - sc0, 32'd0);
        set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        repeat (3) step("idle");

        // flush on consumer, then reload r9 in the decrement cycle
        set_in(1, 0, 0, 2'b00, 1, 9, 3, 0, 0); step("fl.prod");
        set_in(1, 9, 0, 2'b01, 0, 0, 1, 1, 0); step("fl.kill");
        set_in(1, 0, 0, 2'b00, 1, 9, 3, 0, 0); step("fl.reload");
        sc0 = sc_m;
        set_in(1, 0, 9, 2'b10, 0, 0, 1, 0, 0);
        repeat (3) step("fl.cons");
        check("fl.len", stall_cycles - sc0, 32'd2);

        // asynchronous reset while stalling
        set_in(1, 0, 0, 2'b00, 1, 4, LAT_MULDIV, 0, 0); step("ar.prod");
        set_in(1, 4, 0, 2'b01, 0, 0, 1, 0, 0);          step("ar.c1");
        #3;
        check("ar.pre", {31'b0, stall_id}, 32'd1);
        rst = 1'b1;
        #1;
        check("ar.stall", {31'b0, stall_id}, 32'd0);
        check("ar.sc", stall_cycles, 32'd0);
        model_clear();
        set_in(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_in(1, 4, 0, 2'b01, 0, 0, 1, 0, 0); step("ar.post");

        // random traffic over a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            set_in(($urandom % 4) != 0,
                   int'($urandom % 8), int'($urandom % 8),
                   2'($urandom),
                   1'($urandom),
                   int'($urandom % 8),
                   int'($urandom % 8),
                   ($urandom % 10) == 0,
                   ($urandom % 6) == 0);
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-hazard scoreboard for the in-order pipeline, sitting beside the ID stage. It generalises single-case load-use detection to any number of source operands and any producer latency: one down-counter per architectural register tracks cycles until a pending result becomes forwardable. The block raises `stall_id` while any used source is still pending. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers; register 0 is hardwired zero.
- `NUM_SRC`, 2: source operands checked per instruction.
- `MAX_LAT`, 4: largest producer latency tracked.
- `REG_W`, `$clog2(NUM_REGS)`: register-number width.
- `LAT_W`, `$clog2(MAX_LAT+1)`: latency field width.

Ports:
- `clk` input 1: single clock, posedge.
- `rst` input 1: asynchronous, active-high reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_src_num` input NUM_SRC×REG_W: source register numbers.
- `id_src_used` input NUM_SRC: per-source "operand is read" flags.
- `id_dst_we` input 1: the instruction writes a register.
- `id_dst_num` input REG_W: destination register.
- `id_lat` input LAT_W: producer latency class (cycles until forwardable).
- `flush` input 1: kills the ID-stage instruction this cycle.
- `pipe_hold` input 1: the downstream pipeline is frozen (memory wait).
- `stall_id` output 1: the ID instruction must not issue.
- `issue` output 1: the ID instruction issues this cycle.
- `stall_cycles` output 32: saturating count of cycles with `stall_id`=1.

## Operation
- State: `cnt[r]` (LAT_W bits) for r = 1…NUM_REGS-1. `cnt[0]` is constant 0.
- Hazard condition: `hz` is true when, for any source i, `id_src_used[i]` && `id_src_num[i]`≠0 && `cnt[id_src_num[i]]`≠0.
- Stall output: `stall_id` = `id_valid` && !`flush` && `hz`. It is combinational from the registered counters.
- Issue output: `issue` = `id_valid` && !`flush` && !`hz` && !`pipe_hold`.
- Counter update, when `pipe_hold`=0:
  - Every nonzero `cnt` decrements by 1 (saturating at 0).
  - If `issue` && `id_dst_we` && `id_dst_num`≠0, then `cnt[id_dst_num]` loads `min(id_lat, MAX_LAT) - 1`, with `id_lat`=0 treated as 1.
  - On the same register in the same cycle, the load wins over the decrement.
- Counter update, when `pipe_hold`=1: all counters hold and no load occurs. `stall_id` still reflects `hz`.
- `flush` suppresses both the stall and the issue. Counters of already-issued producers keep running.
- Self-dependence: a source equal to the destination is checked against the old `cnt` value before the load.
- `stall_cycles` increments on every cycle with `stall_id`=1 and holds at 0xFFFF_FFFF.
- Latency classes: 1 = ALU (no bubble), 2 = load (one bubble), up to MAX_LAT = multiply/divide.

## Timing
- Reset: all `cnt` = 0 and `stall_cycles` = 0. Consequently `stall_id`=0, and `issue` follows `id_valid` && !`flush` && !`pipe_hold`.
- Reset mid-operation clears all pending state immediately and asynchronously. Nothing stalls after reset.
- Load-use: a consumer arriving in the cycle after a lat=2 producer issues sees `stall_id`=1 for exactly 1 cycle, then issues.
- Stall length: a producer of latency L stalls an immediately following dependent instruction for L-1 cycles, plus any cycles with `pipe_hold`=1.
- Register 0 never stalls and is never loaded.
- Both sources naming the same pending register produce one stall, not a double stall.

## Structure
- Shared package `hazard_pkg` holds:
  - `LAT_ALU`=1, `LAT_LOAD`=2, `LAT_MULDIV`=4.
  - The default `REG_W`.
  - `typedef logic [REG_W-1:0] reg_num_t`.
- One sub-module, `sb_counter`: a per-register LAT_W down-counter with load, hold, async clear, and a `busy` output. It is instantiated with a generate loop for r = 1…NUM_REGS-1.
- The hazard OR-reduction and the stall-cycle counter live in the top level.

## Test plan
- Load-use: issue lat=2 writing r8, next cycle a consumer reads r8 -> `stall_id`=1 for 1 cycle, `issue`=1 on the 2nd cycle, `stall_cycles`=1.
- ALU chain: lat=1 writing r3, then an instruction reading r3 on src1 -> no stall, issue back-to-back.
- Long latency with hold: lat=4 writing r5, consumer of r5 follows, `pipe_hold`=1 for 2 cycles in the middle -> the stall lasts 3+2=5 cycles and the counter freezes during hold.
- r0 and unused operands: producer writes r0 with lat=4; a consumer reads r0, and another has `id_src_used`=0 on pending r7 -> never stalls.
- Flush and reload: while r9 is pending with `cnt`=2, `flush`=1 on its consumer -> `stall_id`=0 and `issue`=0. A later instruction issuing lat=3 to r9 in the same cycle as the decrement -> `cnt[r9]`=2.
- Async reset: `rst` asserted while r4 is pending and the consumer is stalling -> `stall_id` drops without waiting for a clock edge, and `stall_cycles`=0.
